fpu_ret_queue: RTL and testbench

FPU_RET_QUEUE -- requirements
Module: fpu_ret_queue

---
 rtl/fpu_ret_queue.sv | 128 ++++++++++++
 tb/tb_fpu_ret_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ret_queue.sv
// rtl/fpu_ret_queue.sv - FPU issue-to-return latency pipe feeding an ordered completion FIFO toward retire.
module fpu_ret_queue #(
    parameter int DEPTH = 8,
    parameter int LAT   = 4,
    parameter int ID_W  = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_en,
    input  logic [ID_W-1:0]          iss_id,
    output logic                     iss_stall,
    input  logic [13:0]              u_ret,
    input  logic                     u_ret_en,
    input  logic [5:0]               fus,
    input  logic                     flush,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [ID_W-1:0]          out_id,
    output logic [13:0]              out_ret,
    output logic [5:0]               out_fus,
    output logic [5:0]               fsticky,
    input  logic                     fsticky_clr,
    output logic [1:0]               err,
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int EW = ID_W + 20;
    localparam int CW = $clog2(DEPTH + LAT + 1);

    logic [LAT-1:0]  pv_q, pv_d;
    logic [ID_W-1:0] pid_q [LAT];
    logic [ID_W-1:0] pid_d [LAT];
    logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic [5:0]      fst_q, fst_d;
    logic [1:0]      err_q, err_d;
    logic [EW-1:0]   mem_q [DEPTH];

    logic [CW-1:0]   inflight;
    logic            acc, arr, push, pop;
    logic [EW-1:0]   push_data;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(pv_q[i]);
        end
        // Stall counts ops still in flight so every issued op has a FIFO slot reserved.
        iss_stall = (CW'(occ_q) + inflight) >= CW'(DEPTH);
        acc       = iss_en & ~iss_stall & ~flush;
        arr       = pv_q[LAT-1];
        push      = arr & ~flush;
        pop       = (occ_q != '0) & out_rdy & ~flush;
        push_data = {pid_q[LAT-1], (u_ret_en ? u_ret : 14'h0), (u_ret_en ? fus : 6'h0)};

        pv_d[0]  = acc;
        pid_d[0] = iss_id;
        for (int i = 1; i < LAT; i++) begin
            pv_d[i]  = pv_q[i-1];
            pid_d[i] = pid_q[i-1];
        end

        wp_d  = push ? wp_q + AW'(1) : wp_q;
        rp_d  = pop  ? rp_q + AW'(1) : rp_q;
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OW'(1);
        end
        if (flush) begin
            pv_d  = '0;
            wp_d  = '0;
            rp_d  = '0;
            occ_d = '0;
        end

        fst_d = fsticky_clr ? 6'h0 : fst_q;
        if (push && u_ret_en) begin
            fst_d = fst_d | fus;
        end

        err_d = err_q;
        if (push && !u_ret_en) begin
            err_d[0] = 1'b1;
        end
        if ((!arr && u_ret_en && !flush) || (iss_en && iss_stall)) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv_q  <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            occ_q <= '0;
            fst_q <= '0;
            err_q <= '0;
        end else begin
            pv_q  <= pv_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            occ_q <= occ_d;
            fst_q <= fst_d;
            err_q <= err_d;
        end
    end

    // Tags and FIFO payload are qualified by valid/occupancy, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LAT; i++) begin
            pid_q[i] <= pid_d[i];
        end
        if (push) begin
            mem_q[wp_q] <= push_data;
        end
    end

    assign out_vld                   = (occ_q != '0);
    assign {out_id, out_ret, out_fus} = mem_q[rp_q];
    assign occ                       = occ_q;
    assign fsticky                   = fst_q;
    assign err                       = err_q;

endmodule

// File: tb/tb_fpu_ret_queue.sv
// tb/tb_fpu_ret_queue.sv - directed-vector bench for fpu_ret_queue with a queue-based reference model.
module tb_fpu_ret_queue;

    localparam int DEPTH = 8;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_en;
    logic [8:0]  iss_id;
    logic        iss_stall;
    logic [13:0] u_ret;
    logic        u_ret_en;
    logic [5:0]  fus;
    logic        flush;
    logic        out_vld;
    logic        out_rdy;
    logic [8:0]  out_id;
    logic [13:0] out_ret;
    logic [5:0]  out_fus;
    logic [5:0]  fsticky;
    logic        fsticky_clr;
    logic [1:0]  err;
    logic [3:0]  occ;

    fpu_ret_queue #(.DEPTH(DEPTH), .LAT(LAT), .ID_W(9)) dut (
        .clk(clk), .rst(rst), .iss_en(iss_en), .iss_id(iss_id), .iss_stall(iss_stall),
        .u_ret(u_ret), .u_ret_en(u_ret_en), .fus(fus), .flush(flush),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_id(out_id), .out_ret(out_ret),
        .out_fus(out_fus), .fsticky(fsticky), .fsticky_clr(fsticky_clr), .err(err), .occ(occ)
    );

    always #5 clk = ~clk;

    typedef struct { int arr; logic [8:0] id; } fl_t;
    typedef struct { logic [8:0] id; logic [13:0] ret; logic [5:0] fus; } ent_t;

    fl_t      infl[$];
    ent_t     fifo[$];
    logic [5:0] m_fst = '0;
    logic [1:0] m_err = '0;
    int       m_cyc = 0;
    int       n_vec = 0;
    int       n_bad = 0;
    bit       auto_ret = 1'b0;
    bit       s_stall, s_arr, s_pop;
    fl_t      s_f;
    ent_t     s_e;

    function automatic bit m_stall();
        return (fifo.size() + infl.size()) >= DEPTH;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: ops scheduled by arrival cycle, completions as an ordered list.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            infl.delete();
            fifo.delete();
            m_fst = '0;
            m_err = '0;
        end else begin
            s_stall = m_stall();
            s_arr   = (infl.size() > 0) && (infl[0].arr == m_cyc);
            s_pop   = (fifo.size() > 0) && out_rdy;
            if (fsticky_clr) m_fst = '0;
            if (iss_en && s_stall) m_err[1] = 1'b1;
            if (flush) begin
                infl.delete();
                fifo.delete();
            end else begin
                if (s_pop) void'(fifo.pop_front());
                if (s_arr) begin
                    s_f   = infl.pop_front();
                    s_e.id  = s_f.id;
                    s_e.ret = u_ret_en ? u_ret : 14'h0;
                    s_e.fus = u_ret_en ? fus : 6'h0;
                    fifo.push_back(s_e);
                    if (u_ret_en) m_fst = m_fst | fus;
                    else m_err[0] = 1'b1;
                end else if (u_ret_en) begin
                    m_err[1] = 1'b1;
                end
                if (iss_en && !s_stall) begin
                    s_f.arr = m_cyc + LAT;
                    s_f.id  = iss_id;
                    infl.push_back(s_f);
                end
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        chk("iss_stall", iss_stall, m_stall());
        chk("out_vld", out_vld, fifo.size() > 0);
        chk("occ", occ, fifo.size());
        chk("fsticky", fsticky, m_fst);
        chk("err", err, m_err);
        if (fifo.size() > 0) begin
            chk("out_id", out_id, fifo[0].id);
            chk("out_ret", out_ret, fifo[0].ret);
            chk("out_fus", out_fus, fifo[0].fus);
        end
    end

    task automatic tick();
        @(negedge clk);
        if (auto_ret) begin
            if (infl.size() > 0 && infl[0].arr == m_cyc) begin
                u_ret_en = 1'b1;
                u_ret    = {5'h0, infl[0].id};
                fus      = infl[0].id[5:0];
            end else begin
                u_ret_en = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; iss_en = 0; iss_id = '0; u_ret = '0; u_ret_en = 0; fus = '0;
        flush = 0; out_rdy = 0; fsticky_clr = 0;
        tick(); tick();
        chk("rst_occ", occ, 0);
        chk("rst_vld", out_vld, 0);
        chk("rst_stall", iss_stall, 0);
        chk("rst_err", err, 0);
        chk("rst_fst", fsticky, 0);
        rst = 1'b1;

        // single op, return four cycles later, visible the cycle after
        iss_en = 1; iss_id = 9'h05; out_rdy = 1;
        tick(); iss_en = 0;
        tick(); tick(); tick();
        u_ret_en = 1; u_ret = 14'h1234; fus = 6'h02;
        tick(); u_ret_en = 0; fus = '0;
        chk("t1_vld", out_vld, 1);
        chk("t1_id", out_id, 9'h05);
        chk("t1_ret", out_ret, 14'h1234);
        chk("t1_fus", out_fus, 6'h02);
        chk("t1_fst", fsticky, 6'h02);
        tick();
        chk("t1_drain", occ, 0);

        // back-pressure fill until stall
        out_rdy = 0; auto_ret = 1;
        for (int i = 0; i < 20; i++) begin
            iss_en = !m_stall();
            iss_id = 9'(9'h10 + i);
            tick();
        end
        iss_en = 0;
        chk("full_occ", occ, 8);
        chk("full_stall", iss_stall, 1);
        chk("full_err", err, 0);
        chk("full_head", out_id, 9'h10);

        // pop one, refill, arrival coincides with another pop
        out_rdy = 1; tick(); out_rdy = 0;
        iss_en = 1; iss_id = 9'h30; tick(); iss_en = 0;
        tick(); tick(); tick();
        out_rdy = 1; tick(); out_rdy = 0;
        chk("pp_occ", occ, 7);
        chk("pp_head", out_id, 9'h12);

        // drain, then missing return and spurious return
        out_rdy = 1;
        for (int i = 0; i < 12 && fifo.size() > 0; i++) tick();
        out_rdy = 0;
        chk("drain_occ", occ, 0);
        auto_ret = 0; u_ret_en = 0;
        iss_en = 1; iss_id = 9'h41; tick(); iss_en = 0;
        tick(); tick(); tick(); tick();
        chk("miss_id", out_id, 9'h41);
        chk("miss_ret", out_ret, 0);
        chk("miss_err", err, 2'b01);
        u_ret_en = 1; u_ret = 14'h3ff; fus = 6'h3f; tick(); u_ret_en = 0; fus = '0;
        chk("spur_err", err, 2'b11);
        chk("spur_occ", occ, 1);

        // flush with three in flight and two queued
        out_rdy = 1; tick(); out_rdy = 0; auto_ret = 1;
        iss_en = 1; iss_id = 9'h50; tick();
        iss_id = 9'h51; tick();
        iss_en = 0; tick();
        iss_en = 1; iss_id = 9'h52; tick();
        iss_id = 9'h53; tick();
        iss_id = 9'h54; tick();
        iss_en = 0;
        chk("pre_flush_occ", occ, 2);
        flush = 1; u_ret_en = 1; tick();
        flush = 0; u_ret_en = 0;
        chk("flush_occ", occ, 0);
        chk("flush_vld", out_vld, 0);
        chk("flush_err", err, 2'b11);
        repeat (5) tick();
        chk("post_flush_occ", occ, 0);
        chk("post_flush_err", err, 2'b11);

        // sticky clear in the same cycle as a flagged push
        auto_ret = 0;
        iss_en = 1; iss_id = 9'h60; tick(); iss_en = 0;
        tick(); tick(); tick();
        u_ret_en = 1; u_ret = 14'h0abc; fus = 6'h10; fsticky_clr = 1;
        tick(); u_ret_en = 0; fus = '0; fsticky_clr = 0;
        chk("clr_fst", fsticky, 6'h10);
        chk("clr_ret", out_ret, 14'h0abc);
        fsticky_clr = 1; tick(); fsticky_clr = 0;
        chk("clr_only", fsticky, 0);

        // asynchronous reset mid-burst
        auto_ret = 1;
        for (int i = 0; i < 4; i++) begin
            iss_en = 1; iss_id = 9'(9'h70 + i); tick();
        end
        iss_en = 0;
        repeat (4) tick();
        chk("pre_rst_occ", occ, 5);
        iss_en = 1; iss_id = 9'h74;
        #2 rst = 1'b0;
        #1;
        chk("arst_occ", occ, 0);
        chk("arst_vld", out_vld, 0);
        chk("arst_stall", iss_stall, 0);
        chk("arst_fst", fsticky, 0);
        chk("arst_err", err, 0);
        iss_en = 0;
        tick();
        rst = 1'b1;
        iss_en = 1; iss_id = 9'h80; tick(); iss_en = 0;
        repeat (4) tick();
        chk("rel_occ", occ, 1);
        chk("rel_id", out_id, 9'h80);
        auto_ret = 0; u_ret_en = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
